nibble_bus_memory: RTL and testbench
====================================

# nibble_bus_memory

Memory and bus-monitor stage sitting directly on the far side of the 4-bit CPU's nibble bus. It decodes each bus cycle (instruction fetch phase 1/2/3, zero-page load, zero-page store), returns the addressed nibble combinationally on the read bus, and commits stores. It holds a host-programmable instruction memory, a 16-nibble zero-page data RAM, a bus-protocol checker and a retired-instruction counter for bring-up and verification.

## Interface
Parameters:
- PC_BITS, 6, implemented instruction-address bits; program memory holds 2^PC_BITS instructions of 3 nibbles each.
- CNT_BITS, 16, width of instr_count and err_count.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous reset, active-high.
- bus_active  input  1  high while the CPU is out of reset; checker and counters ignore the bus when low.
- bus_addr  input  8  CPU address byte (fetch: pc[9:2]; load/store: zero-page address in [3:0]).
- bus_ctl  input  4  CPU control nibble (bus bits 7:4).
- bus_wdata  input  4  CPU write nibble (bus bits 3:0).
- bus_rdata  output  4  nibble returned to the CPU.
- prog_we  input  1  host write strobe.
- prog_sel  input  1  0 = program memory, 1 = data RAM.
- prog_addr  input  PC_BITS+2  program: {phase[1:0], index}; data RAM: low 4 bits.
- prog_data  input  4  host write nibble.
- proto_err  output  1  sticky protocol-violation flag.
- range_err  output  1  sticky flag: fetch beyond implemented program memory.
- instr_count  output  CNT_BITS  instructions fetched (completed phase-3 cycles).
- err_count  output  CNT_BITS  protocol violations, saturating.

## Operation
- Cycle decode: bus_ctl[1:0] = 11 → data access, where bus_ctl[3:2] = 01 is LOAD and 00 is STORE; other 11 encodings are illegal (protocol error, bus_rdata = 0). bus_ctl[1:0] = 00/01/10 → fetch phase 1/2/3. Encoding 11 never denotes a fetch.
- Fetch: pc = {bus_addr, bus_ctl[3:2]} (10 bits). If pc[9:PC_BITS] = 0, bus_rdata = program bank[phase][pc[PC_BITS-1:0]]; otherwise bus_rdata = 0 and range_err is set (sticky).
- LOAD: bus_rdata = data_ram[bus_addr[3:0]]; bus_addr[7:4] ignored.
- STORE: data_ram[bus_addr[3:0]] <= bus_wdata at the edge ending the cycle; bus_rdata = 0.
- Host write: when prog_we, write prog_data to the selected memory at the edge. prog_addr phase field 11 is ignored. A host write and a CPU store to the same data address in one cycle: host wins.
- Checker FSM (active only when bus_active): states EXP_F1, EXP_F2, EXP_F3, EXP_ANY. Transitions: F1 seen → EXP_F2; F2 → EXP_F3; F3 → EXP_ANY; in EXP_ANY, F1 → EXP_F2, LOAD/STORE → EXP_F1. Violations: any other cycle type, an illegal encoding, or pc during F2/F3 differing from pc latched at F1. On a violation set proto_err, increment err_count (saturating at all-ones), and resynchronise: if the offending cycle is F1 go to EXP_F2, otherwise EXP_F1.
- bus_active low: FSM forced to EXP_F1 (no error counted); memories still respond and stores still commit.
- instr_count increments by 1 on each F3 cycle with bus_active high, wraps at all-ones.

## Timing
- bus_rdata is purely combinational from bus_addr, bus_ctl and memory contents; zero cycles latency (the CPU samples it at the same edge).
- Writes (host or store) visible on bus_rdata from the cycle after the write edge.
- Reset (rst high at an edge): data RAM all zeros, FSM EXP_F1, proto_err 0, range_err 0, instr_count 0, err_count 0. Program memory is not reset, so a loaded program survives. Reset mid-instruction discards the latched pc; the first post-reset cycle must be F1 or it counts as an error.
- Reset has priority over all writes in the same cycle.

## Test plan
- Host loads instruction 0 = nibbles {4,A,5} into phases 0/1/2; CPU-style F1/F2/F3 at pc 0 (bus_addr 00, bus_ctl 0000/0001/0010) → bus_rdata 4, A, 5; instr_count 1; proto_err 0.
- STORE with bus_addr 03, bus_ctl 0011, bus_wdata 9, then LOAD with bus_addr 03, bus_ctl 0111 → bus_rdata 9; addr F3 aliases 03 → reads 9.
- F1 then F3 (skipping F2) → proto_err 1, err_count 1, FSM in EXP_F1; next full F1/F2/F3 accepted with no further errors.
- F1 at pc 5 then F2 at pc 6 → err_count increments; fetch at pc 64 with PC_BITS=6 → bus_rdata 0, range_err 1.
- Host write data address 2 = 7 in the same cycle as CPU store address 2 = 1 → address 2 reads 7; rst asserted afterwards → address 2 reads 0, counters 0, program nibbles intact.
- Drive 2^CNT_BITS+2 violations → err_count holds at all-ones; bus_active low during illegal cycles → no count change.

Source files
------------

// File: rtl/nibble_bus_memory_if.sv
// rtl/nibble_bus_memory_if.sv - nibble bus signal bundle between the 4-bit CPU and its memory stage

interface nibble_bus_memory_if;
   logic       bus_active;
   logic [7:0] bus_addr;
   logic [3:0] bus_ctl;
   logic [3:0] bus_wdata;
   logic [3:0] bus_rdata;

   modport master (
      output bus_active,
      output bus_addr,
      output bus_ctl,
      output bus_wdata,
      input  bus_rdata
   );

   modport slave (
      input  bus_active,
      input  bus_addr,
      input  bus_ctl,
      input  bus_wdata,
      output bus_rdata
   );
endinterface

// File: rtl/nibble_bus_memory.sv
// rtl/nibble_bus_memory.sv - program/data memory, bus-protocol checker and instruction counter on the nibble bus

module nibble_bus_memory #(
   parameter int PC_BITS  = 6,
   parameter int CNT_BITS = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   nibble_bus_memory_if.slave    bus,
   input  logic                  prog_we,
   input  logic                  prog_sel,
   input  logic [PC_BITS+1:0]    prog_addr,
   input  logic [3:0]            prog_data,
   output logic                  proto_err,
   output logic                  range_err,
   output logic [CNT_BITS-1:0]   instr_count,
   output logic [CNT_BITS-1:0]   err_count
);

   localparam int DEPTH = 1 << PC_BITS;

   typedef enum logic [1:0] {
      EXP_F1  = 2'd0,
      EXP_F2  = 2'd1,
      EXP_F3  = 2'd2,
      EXP_ANY = 2'd3
   } chk_state_t;

   // Three instruction banks (one per fetch phase) and the zero-page RAM.
   logic [3:0] prog_mem [0:2][0:DEPTH-1];
   logic [3:0] data_ram [0:15];

   chk_state_t state;
   logic [9:0] pc_latched;

   // Bus cycle decode
   logic         is_fetch;
   logic         is_f1;
   logic         is_f2;
   logic         is_f3;
   logic         is_load;
   logic         is_store;
   logic [9:0]   pc;
   logic         in_range;
   logic [PC_BITS-1:0] pc_idx;
   logic         violation;
   chk_state_t   next_state;

   // Host-side decode
   logic [1:0]         host_phase;
   logic [PC_BITS-1:0] host_idx;

   assign pc       = {bus.bus_addr, bus.bus_ctl[3:2]};
   assign pc_idx   = pc[PC_BITS-1:0];
   assign in_range = (pc >> PC_BITS) == 10'd0;
   assign is_fetch = bus.bus_ctl[1:0] != 2'b11;
   assign is_f1    = bus.bus_ctl[1:0] == 2'b00;
   assign is_f2    = bus.bus_ctl[1:0] == 2'b01;
   assign is_f3    = bus.bus_ctl[1:0] == 2'b10;
   assign is_load  = bus.bus_ctl == 4'b0111;
   assign is_store = bus.bus_ctl == 4'b0011;

   assign host_phase = prog_addr[PC_BITS+1:PC_BITS];
   assign host_idx   = prog_addr[PC_BITS-1:0];

   // Read path: zero latency, the CPU samples it at the edge ending the cycle.
   always_comb begin
      bus.bus_rdata = 4'h0;
      if (is_fetch) begin
         if (in_range) begin
            bus.bus_rdata = prog_mem[bus.bus_ctl[1:0]][pc_idx];
         end
      end else if (is_load) begin
         bus.bus_rdata = data_ram[bus.bus_addr[3:0]];
      end
   end

   // Checker: which cycle types are legal now, and where to go next.
   // Illegal 11 encodings match none of the legal cases, so they always violate.
   always_comb begin
      violation = 1'b0;
      case (state)
         EXP_F1:  violation = !is_f1;
         EXP_F2:  violation = !(is_f2 && pc == pc_latched);
         EXP_F3:  violation = !(is_f3 && pc == pc_latched);
         EXP_ANY: violation = !(is_f1 || is_load || is_store);
         default: violation = 1'b1;
      endcase

      // An F1 always starts a new instruction, whether it was legal or a resync point.
      if (is_f1) begin
         next_state = EXP_F2;
      end else if (!violation && is_f2) begin
         next_state = EXP_F3;
      end else if (!violation && is_f3) begin
         next_state = EXP_ANY;
      end else begin
         next_state = EXP_F1;
      end
   end

   // Program memory is never cleared so a loaded program survives reset; reset still blocks writes.
   always_ff @(posedge clk) begin
      if (!rst && prog_we && !prog_sel && host_phase != 2'b11) begin
         prog_mem[host_phase][host_idx] <= prog_data;
      end
   end

   // Data RAM: CPU store first, host write afterwards so the host wins on a collision.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 16; i++) begin
            data_ram[i] <= 4'h0;
         end
      end else begin
         if (is_store) begin
            data_ram[bus.bus_addr[3:0]] <= bus.bus_wdata;
         end
         if (prog_we && prog_sel) begin
            data_ram[prog_addr[3:0]] <= prog_data;
         end
      end
   end

   // Protocol checker FSM with sticky flags and counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EXP_F1;
         pc_latched  <= 10'd0;
         proto_err   <= 1'b0;
         range_err   <= 1'b0;
         instr_count <= '0;
         err_count   <= '0;
      end else if (!bus.bus_active) begin
         state <= EXP_F1;
      end else begin
         state <= next_state;
         if (is_f1) begin
            pc_latched <= pc;
         end
         if (is_fetch && !in_range) begin
            range_err <= 1'b1;
         end
         if (is_f3) begin
            instr_count <= instr_count + 1'b1;
         end
         if (violation) begin
            proto_err <= 1'b1;
            if (err_count != {CNT_BITS{1'b1}}) begin
               err_count <= err_count + 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_nibble_bus_memory.sv
// tb/tb_nibble_bus_memory.sv - directed self-checking bench for nibble_bus_memory

module tb_nibble_bus_memory;
   localparam int PC_BITS  = 6;
   localparam int CNT_BITS = 8;

   logic clk;
   logic rst;
   logic prog_we;
   logic prog_sel;
   logic [PC_BITS+1:0] prog_addr;
   logic [3:0] prog_data;
   logic proto_err;
   logic range_err;
   logic [CNT_BITS-1:0] instr_count;
   logic [CNT_BITS-1:0] err_count;

   int checks;
   int failures;

   nibble_bus_memory_if bus_if ();

   nibble_bus_memory #(.PC_BITS(PC_BITS), .CNT_BITS(CNT_BITS)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus_if),
      .prog_we     (prog_we),
      .prog_sel    (prog_sel),
      .prog_addr   (prog_addr),
      .prog_data   (prog_data),
      .proto_err   (proto_err),
      .range_err   (range_err),
      .instr_count (instr_count),
      .err_count   (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic act, input logic [7:0] addr, input logic [3:0] ctl, input logic [3:0] wd);
      bus_if.bus_active = act;
      bus_if.bus_addr   = addr;
      bus_if.bus_ctl    = ctl;
      bus_if.bus_wdata  = wd;
      #1;
   endtask

   task automatic host(input logic sel, input logic [PC_BITS+1:0] addr, input logic [3:0] data);
      prog_we   = 1'b1;
      prog_sel  = sel;
      prog_addr = addr;
      prog_data = data;
      cyc();
      prog_we   = 1'b0;
   endtask

   initial begin
      checks = 0;
      failures = 0;
      rst = 1'b1;
      prog_we = 1'b0;
      prog_sel = 1'b0;
      prog_addr = '0;
      prog_data = 4'h0;
      drive(1'b0, 8'h00, 4'h0, 4'h0);
      cyc();
      cyc();
      rst = 1'b0;

      // Reset state
      check("rst_proto_err", 16'(proto_err), 16'h0);
      check("rst_range_err", 16'(range_err), 16'h0);
      check("rst_instr_count", 16'(instr_count), 16'h0);
      check("rst_err_count", 16'(err_count), 16'h0);
      drive(1'b0, 8'h03, 4'b0111, 4'h0);
      check("rst_ram3", 16'(bus_if.bus_rdata), 16'h0);

      // Load instruction 0 = {4,A,5}
      host(1'b0, 8'h00, 4'h4);
      host(1'b0, 8'h40, 4'hA);
      host(1'b0, 8'h80, 4'h5);
      host(1'b0, 8'hC0, 4'hF);   // phase 11 must be ignored

      drive(1'b1, 8'h00, 4'b0000, 4'h0);
      check("f1_rdata", 16'(bus_if.bus_rdata), 16'h4);
      cyc();
      drive(1'b1, 8'h00, 4'b0001, 4'h0);
      check("f2_rdata", 16'(bus_if.bus_rdata), 16'hA);
      cyc();
      drive(1'b1, 8'h00, 4'b0010, 4'h0);
      check("f3_rdata", 16'(bus_if.bus_rdata), 16'h5);
      cyc();
      check("fetch_instr_count", 16'(instr_count), 16'h1);
      check("fetch_proto_err", 16'(proto_err), 16'h0);

      // Store then load (load done with bus inactive to keep the checker quiet)
      drive(1'b1, 8'h03, 4'b0011, 4'h9);
      check("store_rdata", 16'(bus_if.bus_rdata), 16'h0);
      cyc();
      drive(1'b0, 8'h03, 4'b0111, 4'h0);
      check("load_03", 16'(bus_if.bus_rdata), 16'h9);
      drive(1'b0, 8'hF3, 4'b0111, 4'h0);
      check("load_f3_alias", 16'(bus_if.bus_rdata), 16'h9);
      drive(1'b0, 8'h03, 4'b1011, 4'h0);
      check("illegal_rdata", 16'(bus_if.bus_rdata), 16'h0);
      cyc();
      check("store_no_err", 16'(err_count), 16'h0);

      // F1 then F3: one violation, F3 still counted
      drive(1'b1, 8'h00, 4'b0000, 4'h0);
      cyc();
      drive(1'b1, 8'h00, 4'b0010, 4'h0);
      cyc();
      check("skip_proto_err", 16'(proto_err), 16'h1);
      check("skip_err_count", 16'(err_count), 16'h1);
      check("skip_instr_count", 16'(instr_count), 16'h2);
      drive(1'b1, 8'h00, 4'b0000, 4'h0);
      cyc();
      drive(1'b1, 8'h00, 4'b0001, 4'h0);
      cyc();
      drive(1'b1, 8'h00, 4'b0010, 4'h0);
      cyc();
      check("resync_err_count", 16'(err_count), 16'h1);
      check("resync_instr_count", 16'(instr_count), 16'h3);

      // pc mismatch: F1 at pc 5, F2 at pc 6
      drive(1'b1, 8'h01, 4'b0100, 4'h0);
      cyc();
      drive(1'b1, 8'h01, 4'b1001, 4'h0);
      cyc();
      check("pc_mismatch_err", 16'(err_count), 16'h2);
      check("range_err_before", 16'(range_err), 16'h0);

      // Fetch at pc 64 is beyond 6-bit program memory
      drive(1'b1, 8'h10, 4'b0000, 4'h0);
      check("range_rdata", 16'(bus_if.bus_rdata), 16'h0);
      cyc();
      check("range_err", 16'(range_err), 16'h1);
      check("range_no_proto", 16'(err_count), 16'h2);

      // Host and CPU write data address 2 in one cycle: host wins
      prog_we = 1'b1;
      prog_sel = 1'b1;
      prog_addr = 8'h02;
      prog_data = 4'h7;
      drive(1'b0, 8'h02, 4'b0011, 4'h1);
      cyc();
      prog_we = 1'b0;
      drive(1'b0, 8'h02, 4'b0111, 4'h0);
      check("collision_host_wins", 16'(bus_if.bus_rdata), 16'h7);

      // Reset with a simultaneous host write to data address 5: reset wins
      rst = 1'b1;
      prog_we = 1'b1;
      prog_sel = 1'b1;
      prog_addr = 8'h05;
      prog_data = 4'h6;
      cyc();
      rst = 1'b0;
      prog_we = 1'b0;
      drive(1'b0, 8'h02, 4'b0111, 4'h0);
      check("post_rst_ram2", 16'(bus_if.bus_rdata), 16'h0);
      drive(1'b0, 8'h05, 4'b0111, 4'h0);
      check("post_rst_ram5", 16'(bus_if.bus_rdata), 16'h0);
      check("post_rst_instr", 16'(instr_count), 16'h0);
      check("post_rst_err", 16'(err_count), 16'h0);
      check("post_rst_proto", 16'(proto_err), 16'h0);
      check("post_rst_range", 16'(range_err), 16'h0);
      drive(1'b0, 8'h00, 4'b0000, 4'h0);
      check("prog_kept_p0", 16'(bus_if.bus_rdata), 16'h4);
      drive(1'b0, 8'h00, 4'b0001, 4'h0);
      check("prog_kept_p1", 16'(bus_if.bus_rdata), 16'hA);
      drive(1'b0, 8'h00, 4'b0010, 4'h0);
      check("prog_kept_p2", 16'(bus_if.bus_rdata), 16'h5);

      // First post-reset cycle is F2: error
      drive(1'b1, 8'h00, 4'b0001, 4'h0);
      cyc();
      check("post_rst_f2_err", 16'(err_count), 16'h1);

      // 2^CNT_BITS+2 violations in total: saturate
      for (int i = 0; i < (1 << CNT_BITS) + 1; i++) begin
         drive(1'b1, 8'h00, 4'b1011, 4'h0);
         cyc();
      end
      check("sat_err_count", 16'(err_count), 16'hFF);
      check("sat_proto_err", 16'(proto_err), 16'h1);

      // Inactive bus: illegal cycles and F3s change nothing
      for (int i = 0; i < 3; i++) begin
         drive(1'b0, 8'h00, 4'b1111, 4'h0);
         cyc();
         drive(1'b0, 8'h00, 4'b0010, 4'h0);
         cyc();
      end
      check("inactive_err_count", 16'(err_count), 16'hFF);
      check("inactive_instr_count", 16'(instr_count), 16'h0);
      drive(1'b1, 8'h00, 4'b0010, 4'h0);
      cyc();
      check("active_f3_count", 16'(instr_count), 16'h1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end
endmodule
